// File: rtl/flexbex_ibex_hpm_unit.sv
// Hardware performance monitor: N_CNT event counters with per-counter event select,
// saturate/irq options, global inhibit mask and sticky overflow status, all CSR-mapped.
module flexbex_ibex_hpm_unit #(
    parameter int N_CNT = 8,
    parameter int CNT_W = 64,
    parameter int N_EVT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_access_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [31:0]      csr_wdata_i,
    input  logic [1:0]       csr_op_i,
    output logic [31:0]      csr_rdata_o,
    output logic             csr_hit_o,
    input  logic [N_EVT-1:0] events_i,
    output logic             ovf_irq_o
);

    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_EVSEL   = 12'h323;
    localparam logic [11:0] ADDR_CNT_LO  = 12'hB03;
    localparam logic [11:0] ADDR_CNT_HI  = 12'hB83;
    localparam logic [11:0] ADDR_STATUS  = 12'h7C0;
    localparam bit          HAS_HI       = (CNT_W > 32);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    // architectural state
    logic [N_CNT-1:0] inhibit_q;
    logic [N_CNT-1:0] status_q;
    logic [N_CNT-1:0] inc_q;
    logic [7:0]       sel_q    [N_CNT];
    logic [N_CNT-1:0] irq_en_q;
    logic [N_CNT-1:0] sat_q;
    logic [CNT_W-1:0] cnt_q    [N_CNT];

    // decode and datapath
    logic             hit_inhibit;
    logic             hit_status;
    logic [N_CNT-1:0] hit_evsel;
    logic [N_CNT-1:0] hit_lo;
    logic [N_CNT-1:0] hit_hi;
    logic             any_hit;
    logic [31:0]      old_val;
    logic [31:0]      wr_val;
    logic             wr_en;
    logic [63:0]      cnt_ext  [N_CNT];
    logic [CNT_W-1:0] cnt_d    [N_CNT];
    logic [N_CNT-1:0] ovf_set;
    logic [N_CNT-1:0] evt_src;
    logic [N_CNT-1:0] inhibit_d;
    logic [N_CNT-1:0] status_d;

    for (genvar k = 0; k < N_CNT; k++) begin : g_ext
        assign cnt_ext[k] = 64'(cnt_q[k]);
    end

    always_comb begin
        hit_inhibit = (csr_addr_i == ADDR_INHIBIT);
        hit_status  = (csr_addr_i == ADDR_STATUS);
        for (int k = 0; k < N_CNT; k++) begin
            hit_evsel[k] = (csr_addr_i == ADDR_EVSEL + 12'(k));
            hit_lo[k]    = (csr_addr_i == ADDR_CNT_LO + 12'(k));
            hit_hi[k]    = HAS_HI && (csr_addr_i == ADDR_CNT_HI + 12'(k));
        end
        any_hit   = hit_inhibit | hit_status | (|hit_evsel) | (|hit_lo) | (|hit_hi);
        csr_hit_o = csr_access_i & any_hit;
    end

    // Current value of the addressed register; also the "old" operand for set/clear.
    always_comb begin
        old_val = '0;
        if (hit_inhibit) old_val = 32'(inhibit_q);
        if (hit_status)  old_val = 32'(status_q);
        for (int k = 0; k < N_CNT; k++) begin
            if (hit_evsel[k]) old_val = {sat_q[k], irq_en_q[k], 22'd0, sel_q[k]};
            if (hit_lo[k])    old_val = cnt_ext[k][31:0];
            if (hit_hi[k])    old_val = cnt_ext[k][63:32];
        end
        csr_rdata_o = csr_hit_o ? old_val : 32'd0;
    end

    always_comb begin
        case (csr_op_e'(csr_op_i))
            OP_WRITE: wr_val = csr_wdata_i;
            OP_SET:   wr_val = old_val | csr_wdata_i;
            OP_CLEAR: wr_val = old_val & ~csr_wdata_i;
            default:  wr_val = old_val;
        endcase
        wr_en = csr_hit_o && (csr_op_e'(csr_op_i) != OP_READ);
    end

    // sel=0 and sel>N_EVT never match any event index, so they count nothing.
    always_comb begin
        for (int k = 0; k < N_CNT; k++) begin
            evt_src[k] = 1'b0;
            for (int e = 0; e < N_EVT; e++) begin
                if (sel_q[k] == 8'(e + 1)) evt_src[k] = events_i[e];
            end
        end
    end

    // A CSR write to either half wins over the increment landing the same cycle.
    always_comb begin
        ovf_set = '0;
        for (int k = 0; k < N_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (wr_en && hit_lo[k]) begin
                cnt_d[k] = CNT_W'({cnt_ext[k][63:32], wr_val});
            end else if (wr_en && hit_hi[k]) begin
                cnt_d[k] = CNT_W'({wr_val, cnt_ext[k][31:0]});
            end else if (inc_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_set[k] = 1'b1;
                    cnt_d[k]   = sat_q[k] ? CNT_MAX : '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        inhibit_d = inhibit_q;
        if (wr_en && hit_inhibit) inhibit_d = wr_val[N_CNT-1:0];
        status_d = status_q;
        if (wr_en && hit_status) status_d = wr_val[N_CNT-1:0];
        status_d = status_d | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit_q <= '0;
            status_q  <= '0;
            inc_q     <= '0;
            irq_en_q  <= '0;
            sat_q     <= '0;
            ovf_irq_o <= 1'b0;
            for (int k = 0; k < N_CNT; k++) begin
                sel_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            inhibit_q <= inhibit_d;
            status_q  <= status_d;
            inc_q     <= evt_src & ~inhibit_q;
            ovf_irq_o <= |(status_q & irq_en_q);
            for (int k = 0; k < N_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
                if (wr_en && hit_evsel[k]) begin
                    sel_q[k]    <= wr_val[7:0];
                    irq_en_q[k] <= wr_val[30];
                    sat_q[k]    <= wr_val[31];
                end
            end
        end
    end

endmodule

// File: tb/tb_flexbex_ibex_hpm_unit.sv
// Bench for flexbex_ibex_hpm_unit: directed scenarios with literal expectations,
// then randomized CSR/event traffic checked every cycle against a behavioural model.
module tb_flexbex_ibex_hpm_unit;

    localparam int N_CNT = 8;
    localparam int CNT_W = 64;
    localparam int N_EVT = 16;
    localparam logic [63:0] CMASK = {64{1'b1}} >> (64 - CNT_W);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             csr_access_i = 1'b0;
    logic [11:0]      csr_addr_i = '0;
    logic [31:0]      csr_wdata_i = '0;
    logic [1:0]       csr_op_i = '0;
    logic [31:0]      csr_rdata_o;
    logic             csr_hit_o;
    logic [N_EVT-1:0] events_i = '0;
    logic             ovf_irq_o;

    int checks = 0;
    int errors = 0;

    flexbex_ibex_hpm_unit #(.N_CNT(N_CNT), .CNT_W(CNT_W), .N_EVT(N_EVT)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_access_i (csr_access_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_op_i     (csr_op_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_hit_o    (csr_hit_o),
        .events_i     (events_i),
        .ovf_irq_o    (ovf_irq_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]      m_cnt [N_CNT];
    logic [31:0]      m_sel [N_CNT];
    logic [N_CNT-1:0] m_inh;
    logic [N_CNT-1:0] m_st;
    logic [N_CNT-1:0] m_pend;
    logic             m_irq;

    function automatic logic m_mapped(input logic [11:0] a);
        if (a == 12'h320 || a == 12'h7C0) return 1'b1;
        for (int k = 0; k < N_CNT; k++) begin
            if (a == 12'(12'h323 + k)) return 1'b1;
            if (a == 12'(12'hB03 + k)) return 1'b1;
            if (CNT_W > 32 && a == 12'(12'hB83 + k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (a == 12'h320) return 32'(m_inh);
        if (a == 12'h7C0) return 32'(m_st);
        for (int k = 0; k < N_CNT; k++) begin
            if (a == 12'(12'h323 + k)) return m_sel[k];
            if (a == 12'(12'hB03 + k)) return m_cnt[k][31:0];
            if (CNT_W > 32 && a == 12'(12'hB83 + k)) return m_cnt[k][63:32];
        end
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N_CNT; k++) begin
            m_cnt[k] = '0;
            m_sel[k] = '0;
        end
        m_inh  = '0;
        m_st   = '0;
        m_pend = '0;
        m_irq  = 1'b0;
    endtask

    // One clock edge of the block as the requirements describe it.
    task automatic m_step();
        logic [31:0]      old_v;
        logic [31:0]      wv;
        logic             wr;
        logic [N_CNT-1:0] hw;
        logic [N_CNT-1:0] npend;
        logic [N_CNT-1:0] ien;
        int               s;
        old_v = m_read(csr_addr_i);
        wr    = csr_access_i && m_mapped(csr_addr_i) && (csr_op_i != 2'd0);
        case (csr_op_i)
            2'd1:    wv = csr_wdata_i;
            2'd2:    wv = old_v | csr_wdata_i;
            2'd3:    wv = old_v & ~csr_wdata_i;
            default: wv = old_v;
        endcase
        hw = '0;
        for (int k = 0; k < N_CNT; k++) begin
            ien[k] = m_sel[k][30];
            s = int'(m_sel[k][7:0]);
            npend[k] = (s >= 1 && s <= N_EVT) ? (events_i[s-1] & ~m_inh[k]) : 1'b0;
        end
        m_irq = |(m_st & ien);
        for (int k = 0; k < N_CNT; k++) begin
            if (wr && csr_addr_i == 12'(12'hB03 + k)) begin
                m_cnt[k] = {m_cnt[k][63:32], wv} & CMASK;
            end else if (wr && CNT_W > 32 && csr_addr_i == 12'(12'hB83 + k)) begin
                m_cnt[k] = {wv, m_cnt[k][31:0]} & CMASK;
            end else if (m_pend[k]) begin
                if (m_cnt[k] == CMASK) begin
                    hw[k] = 1'b1;
                    if (!m_sel[k][31]) m_cnt[k] = '0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 64'd1;
                end
            end
            if (wr && csr_addr_i == 12'(12'h323 + k)) m_sel[k] = wv & 32'hC000_00FF;
        end
        if (wr && csr_addr_i == 12'h320) m_inh = wv[N_CNT-1:0];
        if (wr && csr_addr_i == 12'h7C0) m_st = wv[N_CNT-1:0];
        m_st   = m_st | hw;
        m_pend = npend;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic exp_hit;
        exp_hit = csr_access_i && m_mapped(csr_addr_i);
        chk("cyc_hit", 64'(csr_hit_o), 64'(exp_hit));
        chk("cyc_rdata", 64'(csr_rdata_o), exp_hit ? 64'(m_read(csr_addr_i)) : 64'd0);
        chk("cyc_irq", 64'(ovf_irq_o), 64'(m_irq));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic acc, input logic [11:0] a, input logic [31:0] d,
                         input logic [1:0] op, input logic [N_EVT-1:0] ev);
        @(posedge clk);
        #1;
        csr_access_i = acc;
        csr_addr_i   = a;
        csr_wdata_i  = d;
        csr_op_i     = op;
        events_i     = ev;
    endtask

    task automatic read_chk(input string nm, input logic [11:0] a, input logic [31:0] exp,
                            input logic [N_EVT-1:0] ev);
        drive(1'b1, a, 32'd0, 2'd0, ev);
        @(negedge clk);
        chk(nm, 64'(csr_rdata_o), 64'(exp));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op,
                      input logic [N_EVT-1:0] ev);
        drive(1'b1, a, d, op, ev);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp35 [14];
        int kind;
        int k;
        logic [11:0] a;
        logic [31:0] d;
        logic [1:0]  op;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        read_chk("rst_inhibit", 12'h320, 32'd0, '0);
        read_chk("rst_status", 12'h7C0, 32'd0, '0);
        read_chk("rst_cnt3_lo", 12'hB06, 32'd0, '0);
        chk("rst_irq", 64'(ovf_irq_o), 64'd0);
        read_chk("unmapped", 12'h321, 32'd0, '0);
        chk("unmapped_hit", 64'(csr_hit_o), 64'd0);

        // basic counting on counter 0 from events_i[0]
        wr(12'h323, 32'd1, 2'd1, '0);
        for (int i = 0; i < 7; i++)
            read_chk("cnt0_basic", 12'hB03, (i < 2) ? 32'd0 : 32'(i - 1),
                     (i < 5) ? 16'h0001 : 16'h0000);

        // wrap of counter 1 with irq enable
        wr(12'h324, 32'h4000_0002, 2'd1, '0);
        read_chk("evsel1_rd", 12'h324, 32'h4000_0002, '0);
        wr(12'hB04, 32'hFFFF_FFFE, 2'd1, '0);
        wr(12'hB84, 32'hFFFF_FFFF, 2'd1, '0);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1: read_chk("wrap_lo_fe", 12'hB04, 32'hFFFF_FFFE, (i < 2) ? 16'h0002 : 16'h0);
                2: read_chk("wrap_lo_ff", 12'hB04, 32'hFFFF_FFFF, '0);
                3: begin
                    read_chk("wrap_lo_0", 12'hB04, 32'd0, '0);
                    chk("wrap_irq_late", 64'(ovf_irq_o), 64'd0);
                end
                4: begin
                    read_chk("wrap_status", 12'h7C0, 32'd2, '0);
                    chk("wrap_irq", 64'(ovf_irq_o), 64'd1);
                end
                default: read_chk("wrap_hi_0", 12'hB84, 32'd0, '0);
            endcase
        end
        wr(12'h7C0, 32'd2, 2'd3, '0);
        read_chk("status_clr", 12'h7C0, 32'd0, '0);
        read_chk("status_clr2", 12'h7C0, 32'd0, '0);
        chk("irq_drop", 64'(ovf_irq_o), 64'd0);

        // saturating counter 1
        wr(12'h324, 32'hC000_0002, 2'd1, '0);
        wr(12'hB04, 32'hFFFF_FFFE, 2'd1, '0);
        wr(12'hB84, 32'hFFFF_FFFF, 2'd1, '0);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1: read_chk("sat_lo_fe", 12'hB04, 32'hFFFF_FFFE, 16'h0002);
                2: read_chk("sat_lo_ff", 12'hB04, 32'hFFFF_FFFF, 16'h0002);
                3: read_chk("sat_hold", 12'hB04, 32'hFFFF_FFFF, '0);
                4: begin
                    read_chk("sat_status", 12'h7C0, 32'd2, '0);
                    chk("sat_irq", 64'(ovf_irq_o), 64'd1);
                end
                default: read_chk("sat_hi", 12'hB84, 32'hFFFF_FFFF, '0);
            endcase
        end

        // CSR write beats a landing increment
        drive(1'b0, 12'h0, 32'd0, 2'd0, 16'h0001);
        wr(12'hB03, 32'h10, 2'd1, '0);
        read_chk("wr_prio", 12'hB03, 32'h10, '0);
        read_chk("wr_prio2", 12'hB03, 32'h10, '0);

        // inhibit freezes counter 2, clearing resumes it
        exp35 = '{-1, 0, 0, 1, 2, -1, 4, 5, 5, -1, 5, 5, 6, 7};
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      wr(12'h325, 32'd3, 2'd1, 16'h0004);
            else if (i == 5) wr(12'h320, 32'd4, 2'd2, 16'h0004);
            else if (i == 9) wr(12'h320, 32'd4, 2'd3, 16'h0004);
            else read_chk("inhibit_cnt2", 12'hB05, 32'(exp35[i]), 16'h0004);
        end

        // reset mid-count
        chk("pre_rst_irq", 64'(ovf_irq_o), 64'd1);
        drive(1'b1, 12'hB05, 32'd0, 2'd0, 16'h0004);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_now_rdata", 64'(csr_rdata_o), 64'd0);
        chk("rst_now_irq", 64'(ovf_irq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) read_chk("post_rst_cnt2", 12'hB05, 32'd0, 16'h0004);
        read_chk("post_rst_sel2", 12'h325, 32'd0, 16'h0004);
        read_chk("post_rst_cnt1", 12'hB84, 32'd0, 16'h0004);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            kind = $urandom_range(0, 9);
            k    = $urandom_range(0, N_CNT - 1);
            op   = 2'($urandom_range(0, 3));
            d    = $urandom;
            case (kind)
                0: a = 12'h320;
                1: a = 12'h7C0;
                2: begin
                    a = 12'(12'h323 + k);
                    d = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 22'($urandom),
                         8'($urandom_range(0, N_EVT + 3))};
                end
                3: begin
                    a = 12'(12'hB03 + k);
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
                4: begin
                    a = 12'(12'hB83 + k);
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF;
                end
                5: a = 12'($urandom_range(0, 4095));
                default: begin
                    a  = 12'(($urandom_range(0, 1) == 1) ? 12'hB03 + k : 12'hB83 + k);
                    op = 2'd0;
                end
            endcase
            drive(1'($urandom_range(0, 7) != 0), a, d, op, N_EVT'($urandom));
            if (i == 1000) begin
                #2;
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        drive(1'b0, 12'h0, 32'd0, 2'd0, '0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flexbex_ibex_hpm_unit.md
FLEXBEX_IBEX_HPM_UNIT -- requirements
Module: flexbex_ibex_hpm_unit

Interface
REQ-001 SHALL have parameter N_CNT, default 8, number of counters, legal 1..29.
REQ-002 SHALL have parameter CNT_W, default 64, counter width, legal 32..64.
REQ-003 SHALL have parameter N_EVT, default 16, number of event inputs, legal 1..255.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port csr_access_i  input  1  CSR access valid this cycle.
REQ-007 SHALL have port csr_addr_i  input  12  CSR address.
REQ-008 SHALL have port csr_wdata_i  input  32  CSR write operand.
REQ-009 SHALL have port csr_op_i  input  2  0 read, 1 write, 2 set, 3 clear.
REQ-010 SHALL have port csr_rdata_o  output  32  read data, combinational from current state.
REQ-011 SHALL have port csr_hit_o  output  1  address decodes to this block.
REQ-012 SHALL have port events_i  input  N_EVT  one-cycle event pulses.
REQ-013 SHALL have port ovf_irq_o  output  1  registered overflow interrupt.

Function
REQ-014 SHALL map: inhibit 0x320 (bit k inhibits counter k); event select 0x323+k; counter low 0xB03+k; counter high 0xB83+k; overflow status 0x7C0; k < N_CNT.
REQ-015 SHALL assert csr_hit_o only when csr_access_i=1 and csr_addr_i is mapped; high-half addresses are mapped only when CNT_W>32.
REQ-016 SHALL return 0 on csr_rdata_o when csr_hit_o=0; unimplemented bits read 0.
REQ-017 SHALL form write value as op1 wdata, op2 old|wdata, op3 old&~wdata; op0 writes nothing.
REQ-018 SHALL store event select fields: [7:0] sel, [30] irq enable, [31] saturate; other bits read 0.
REQ-019 SHALL treat sel=0 or sel>N_EVT as no event; else source is events_i[sel-1].
REQ-020 SHALL sample inc_k = source & ~inhibit[k] in cycle t into a register; counter k updates on the edge ending cycle t+1.
REQ-021 SHALL increment modulo 2^CNT_W; on transition all-ones to 0 set status bit k.
REQ-022 SHALL, when saturate=1 and counter is all-ones, hold at all-ones and set status bit k on each further registered increment.
REQ-023 SHALL give CSR write to a counter half priority over a same-cycle increment; that increment is dropped, no overflow flagged.
REQ-024 SHALL leave the other half unchanged on a low- or high-half write; counter high read returns bits CNT_W-1:32 zero-extended.
REQ-025 SHALL give hardware set of a status bit priority over a same-cycle CSR clear of it.
REQ-026 SHALL register ovf_irq_o = OR over k of (status[k] & irq_en[k]), one cycle after status changes.
REQ-027 SHALL apply inhibit/select changes from the cycle after the write; already-sampled increments still land.
REQ-028 SHALL ignore CSR ops when csr_access_i=0.

Reset
REQ-029 SHALL, while rst=1, force all counters 0, inhibit 0, event selects 0, status 0, sample registers 0, ovf_irq_o 0.
REQ-030 SHALL discard in-flight sampled increments on reset assertion; first count possible from events in the first cycle after deassertion.

Verification
REQ-031 SHALL cover: sel[0]=1, events_i[0] high 5 cycles from t -> counter 0 reads 1 in t+2, 5 in t+6.
REQ-032 SHALL cover: counter 1 written 0xFFFF_FFFF_FFFF_FFFE (low then high), one event per cycle, irq enable set -> 0xFF..FF, then 0, status bit 1 set, ovf_irq_o high one cycle later.
REQ-033 SHALL cover: same as REQ-032 with saturate=1 -> counter holds 0xFF..FF, status bit 1 set, no wrap.
REQ-034 SHALL cover: counter low write 0x10 in the cycle a sampled increment lands -> reads 0x10, not 0x11.
REQ-035 SHALL cover: inhibit bit 2 set, events continuous -> counter 2 frozen from second cycle after write; clear -> resumes.
REQ-036 SHALL cover: rst asserted mid-count -> all reads 0, ovf_irq_o 0 immediately, no stale increment after release.
